// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS memory-stage load/store unit.
// Holds the LSU state encoding and the W-stage bubble value.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } lsu_state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int          TIMEOUT_DEF  = 64;
  localparam logic        REGW_BUBBLE  = 1'b0;

endpackage

// File: rtl/mem_stage_lsu.sv
// MEM stage: data-memory request/response FSM plus the MEM/WB register.
// Stalls upstream while a load or store is outstanding.
module mem_stage_lsu
  import mips_mem_pkg::*;
#(
  parameter int          TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegW_enable_M,
  input  logic        Mem_Write_M,
  input  logic        Mem_Read_M,
  input  logic        Result_src_M,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] Write_Data_M,
  input  logic [4:0]  RDadd_M,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        stall_M,
  output logic        bus_err,
  output logic        RegW_enable_W,
  output logic        Result_src_W,
  output logic [31:0] ALU_result_W,
  output logic [31:0] Read_Data_W,
  output logic [4:0]  RDadd_W
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        we_q, we_d;
  logic        regw_q, regw_d;
  logic        rsrc_q, rsrc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  rd_q, rd_d;

  logic        regw_w_q, regw_w_d;
  logic        rsrc_w_q, rsrc_w_d;
  logic [31:0] alu_w_q, alu_w_d;
  logic [31:0] rdat_w_q, rdat_w_d;
  logic [4:0]  rd_w_q, rd_w_d;

  logic        mem_op;
  logic        stall;
  logic        err;

  assign mem_op = Mem_Read_M | Mem_Write_M;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    regw_d   = regw_q;
    rsrc_d   = rsrc_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    regw_w_d = regw_w_q;
    rsrc_w_d = rsrc_w_q;
    alu_w_d  = alu_w_q;
    rdat_w_d = rdat_w_q;
    rd_w_d   = rd_w_q;
    stall    = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          we_d     = Mem_Write_M;
          regw_d   = RegW_enable_M;
          rsrc_d   = Result_src_M;
          addr_d   = ALU_result_M;
          wdata_d  = Write_Data_M;
          rd_d     = RDadd_M;
          rdata_d  = '0;
          cnt_d    = '0;
          stall    = 1'b1;
          regw_w_d = REGW_BUBBLE;
          state_d  = S_REQ;
        end else begin
          regw_w_d = RegW_enable_M;
          rsrc_w_d = Result_src_M;
          alu_w_d  = ALU_result_M;
          rdat_w_d = '0;
          rd_w_d   = RDadd_M;
        end
      end
      S_REQ: begin
        stall    = 1'b1;
        regw_w_d = REGW_BUBBLE;
        if (dmem_req_ready) begin
          if (we_q) begin
            state_d = S_DONE;
          end else if (dmem_rsp_valid) begin
            rdata_d = dmem_rsp_rdata;
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            state_d = S_RSP;
          end
        end
      end
      S_RSP: begin
        stall    = 1'b1;
        regw_w_d = REGW_BUBBLE;
        cnt_d    = cnt_q + CW'(1);
        // a response on the final cycle beats the timeout
        if (dmem_rsp_valid) begin
          rdata_d = dmem_rsp_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          rdata_d = ERR_DATA;
          err     = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        regw_w_d = regw_q;
        rsrc_w_d = rsrc_q;
        alu_w_d  = addr_q;
        rdat_w_d = we_q ? 32'h0 : rdata_q;
        rd_w_d   = rd_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      regw_q   <= 1'b0;
      rsrc_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= '0;
      regw_w_q <= 1'b0;
      rsrc_w_q <= 1'b0;
      alu_w_q  <= '0;
      rdat_w_q <= '0;
      rd_w_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      regw_q   <= regw_d;
      rsrc_q   <= rsrc_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      regw_w_q <= regw_w_d;
      rsrc_w_q <= rsrc_w_d;
      alu_w_q  <= alu_w_d;
      rdat_w_q <= rdat_w_d;
      rd_w_q   <= rd_w_d;
    end
  end

  // the IDLE stall term is combinational on M, so mask it during reset
  assign stall_M        = rst & stall;
  assign bus_err        = err;
  assign dmem_req_valid = (state_q == S_REQ);
  assign dmem_req_we    = dmem_req_valid & we_q;
  assign dmem_req_addr  = dmem_req_valid ? addr_q : 32'h0;
  assign dmem_req_wdata = dmem_req_valid ? wdata_q : 32'h0;

  assign RegW_enable_W  = regw_w_q;
  assign Result_src_W   = rsrc_w_q;
  assign ALU_result_W   = alu_w_q;
  assign Read_Data_W    = rdat_w_q;
  assign RDadd_W        = rd_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed ops, queued W/request
// expectations checked by an independent monitor.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegW_enable_M = 1'b0;
  logic        Mem_Write_M = 1'b0;
  logic        Mem_Read_M = 1'b0;
  logic        Result_src_M = 1'b0;
  logic [31:0] ALU_result_M = '0;
  logic [31:0] Write_Data_M = '0;
  logic [4:0]  RDadd_M = '0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;
  logic        stall_M;
  logic        bus_err;
  logic        RegW_enable_W;
  logic        Result_src_W;
  logic [31:0] ALU_result_W;
  logic [31:0] Read_Data_W;
  logic [4:0]  RDadd_W;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .RegW_enable_M(RegW_enable_M), .Mem_Write_M(Mem_Write_M),
    .Mem_Read_M(Mem_Read_M), .Result_src_M(Result_src_M),
    .ALU_result_M(ALU_result_M), .Write_Data_M(Write_Data_M),
    .RDadd_M(RDadd_M),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .stall_M(stall_M), .bus_err(bus_err),
    .RegW_enable_W(RegW_enable_W), .Result_src_W(Result_src_W),
    .ALU_result_W(ALU_result_W), .Read_Data_W(Read_Data_W),
    .RDadd_W(RDadd_W)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        regw;
    logic        mw;
    logic        mr;
    logic        rsrc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
  } ins_t;

  typedef struct packed {
    logic        regw;
    logic        rsrc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } wexp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  prev_st = 1'b0;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: W results, bubbles and request fields
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (prev_st)
        chk("bubble", {95'h0, RegW_enable_W}, 96'h0);
      if (wq.size() > 0) begin
        wexp_t e;
        e = wq.pop_front();
        chk("w_regs",
            {25'h0, RegW_enable_W, Result_src_W, ALU_result_W,
             Read_Data_W, RDadd_W},
            {25'h0, e});
      end
      if (dmem_req_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_req", 96'h1, 96'h0);
        end else begin
          chk("req_fields",
              {31'h0, dmem_req_we, dmem_req_addr, dmem_req_wdata},
              {31'h0, rq[0]});
          if (dmem_req_ready) void'(rq.pop_front());
        end
      end
      prev_st = stall_M;
    end else begin
      prev_st = 1'b0;
    end
  end

  task automatic set_m(input ins_t i);
    RegW_enable_M = i.regw;
    Mem_Write_M   = i.mw;
    Mem_Read_M    = i.mr;
    Result_src_M  = i.rsrc;
    ALU_result_M  = i.alu;
    Write_Data_M  = i.wd;
    RDadd_M       = i.rd;
  endtask

  // rdy_w: REQ cycles before ready; rsp_w: cycles after accept, -1 = never
  task automatic run(input string nm, input ins_t i, input int rdy_w,
                     input int rsp_w, input logic [31:0] rdat,
                     input wexp_t e, input int exp_st, input int exp_err);
    int  st_n = 0, err_n = 0, wc = 0, sa = 0, guard = 0;
    bit  acc = 0, acc_now, st, ld, done = 0;
    ld = i.mr & ~i.mw;
    @(negedge clk);
    if (i.mr | i.mw) rq.push_back({i.mw, i.alu, i.wd});
    set_m(i);
    while (!done) begin
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = rdat;
      if (acc) begin
        dmem_rsp_valid = (rsp_w > 0) && (sa == rsp_w - 1);
        sa++;
      end else if (dmem_req_valid) begin
        dmem_req_ready = (wc >= rdy_w);
        if (!dmem_req_ready) wc++;
        else if (ld && rsp_w == 0) dmem_rsp_valid = 1'b1;
      end
      #1;
      st = stall_M;
      if (st) st_n++;
      if (bus_err) err_n++;
      acc_now = dmem_req_valid & dmem_req_ready;
      @(posedge clk);
      if (acc_now) acc = 1;
      if (!st) begin
        done = 1;
      end else begin
        guard++;
        if (guard > 300) begin
          chk({nm, "_hang"}, 96'h1, 96'h0);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    if (guard <= 300) wq.push_back(e);
    chk({nm, "_stalls"}, 96'(st_n), 96'(exp_st));
    chk({nm, "_buserr"}, 96'(err_n), 96'(exp_err));
  endtask

  ins_t nop = '0;

  initial begin
    #12;
    chk("rst_req",
        {30'h0, dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata},
        96'h0);
    chk("rst_w",
        {23'h0, stall_M, bus_err, RegW_enable_W, Result_src_W,
         ALU_result_W, Read_Data_W, RDadd_W},
        96'h0);
    @(negedge clk);
    rst = 1'b1;

    run("add", '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5},
        0, -1, 32'h0, '{1'b1, 1'b0, 32'h10, 32'h0, 5'd5}, 0, 0);
    run("alu2", '{1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h99, 5'd31},
        0, -1, 32'h0, '{1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0, 5'd31}, 0, 0);
    run("store", '{1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'hCAFE, 5'd0},
        0, -1, 32'h0, '{1'b0, 1'b0, 32'h100, 32'h0, 5'd0}, 2, 0);
    run("load_wait", '{1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 5'd9},
        3, 2, 32'h1234, '{1'b1, 1'b1, 32'h200, 32'h1234, 5'd9}, 7, 0);
    run("load_fast", '{1'b1, 1'b0, 1'b1, 1'b1, 32'h204, 32'h0, 5'd10},
        0, 0, 32'hA5A5_0001,
        '{1'b1, 1'b1, 32'h204, 32'hA5A5_0001, 5'd10}, 2, 0);
    run("alu3", '{1'b1, 1'b0, 1'b0, 1'b0, 32'h3, 32'h0, 5'd4},
        0, -1, 32'h0, '{1'b1, 1'b0, 32'h3, 32'h0, 5'd4}, 0, 0);
    run("timeout", '{1'b1, 1'b0, 1'b1, 1'b1, 32'h208, 32'h0, 5'd11},
        0, -1, 32'h0, '{1'b1, 1'b1, 32'h208, 32'hDEAD_BEEF, 5'd11}, 66, 1);
    run("late_rsp", '{1'b1, 1'b0, 1'b1, 1'b1, 32'h20C, 32'h0, 5'd13},
        0, 64, 32'h600D, '{1'b1, 1'b1, 32'h20C, 32'h600D, 5'd13}, 66, 0);
    run("both", '{1'b1, 1'b1, 1'b1, 1'b0, 32'h210, 32'h77, 5'd12},
        0, -1, 32'h0, '{1'b1, 1'b0, 32'h210, 32'h0, 5'd12}, 2, 0);

    // reset while a load sits in RSP
    @(negedge clk);
    rq.push_back({1'b0, 32'h300, 32'h0});
    set_m('{1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 5'd7});
    @(negedge clk);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_req",
        {30'h0, dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata},
        96'h0);
    chk("arst_w",
        {23'h0, stall_M, bus_err, RegW_enable_W, Result_src_W,
         ALU_result_W, Read_Data_W, RDadd_W},
        96'h0);
    @(negedge clk);
    set_m(nop);
    rst = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h5555_5555;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    #1;
    chk("late_rsp_ignored",
        {29'h0, stall_M, bus_err, dmem_req_valid, Read_Data_W, RDadd_W},
        96'h0);

    run("add_after", '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 5'd6},
        0, -1, 32'h0, '{1'b1, 1'b0, 32'h44, 32'h0, 5'd6}, 0, 0);
    run("store2", '{1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h1, 5'd0},
        2, -1, 32'h0, '{1'b0, 1'b0, 32'h400, 32'h0, 5'd0}, 4, 0);

    @(negedge clk);
    set_m(nop);
    repeat (3) @(negedge clk);
    chk("wq_drained", 96'(wq.size()), 96'h0);
    chk("rq_drained", 96'(rq.size()), 96'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
